// File: rtl/val_rr_arbiter_pkg.sv
// Shared types for the three-way round-robin burst arbiter: requester index,
// FSM state and one-hot grant encodings.
package val_rr_arbiter_pkg;

   typedef logic [1:0] req_idx_t;

   localparam req_idx_t REQ_A = 2'd0;
   localparam req_idx_t REQ_B = 2'd1;
   localparam req_idx_t REQ_C = 2'd2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam logic [2:0] GNT_NONE = 3'b000;
   localparam logic [2:0] GNT_A    = 3'b001;
   localparam logic [2:0] GNT_B    = 3'b010;
   localparam logic [2:0] GNT_C    = 3'b100;

   function automatic req_idx_t idx_next(input req_idx_t idx);
      return (idx == REQ_C) ? REQ_A : idx + 2'd1;
   endfunction

   function automatic req_idx_t onehot_to_idx(input logic [2:0] gnt);
      req_idx_t idx;
      case (gnt)
         GNT_B:   idx = REQ_B;
         GNT_C:   idx = REQ_C;
         default: idx = REQ_A;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/val_rr_arbiter_pick3.sv
// Combinational round-robin pick over three requests, starting the scan at ptr_i.
// Zero latency; no handshake of its own.
module rr_pick3
   import val_rr_arbiter_pkg::*;
(
   input  logic [2:0] req_i,
   input  req_idx_t   ptr_i,
   output logic [2:0] gnt_o
);

   always_comb begin
      gnt_o = GNT_NONE;
      case (ptr_i)
         REQ_B: begin
            if (req_i[1])      gnt_o = GNT_B;
            else if (req_i[2]) gnt_o = GNT_C;
            else if (req_i[0]) gnt_o = GNT_A;
         end
         REQ_C: begin
            if (req_i[2])      gnt_o = GNT_C;
            else if (req_i[0]) gnt_o = GNT_A;
            else if (req_i[1]) gnt_o = GNT_B;
         end
         default: begin
            if (req_i[0])      gnt_o = GNT_A;
            else if (req_i[1]) gnt_o = GNT_B;
            else if (req_i[2]) gnt_o = GNT_C;
         end
      endcase
   end

endmodule

// File: rtl/val_rr_arbiter.sv
// Round-robin burst arbiter for three requesters into one registered output channel.
// Grant one cycle after request, data two cycles after; beats stall while output is full and downstream not ready.
module val_rr_arbiter
   import val_rr_arbiter_pkg::*;
#(
   parameter int N         = 32,
   parameter int MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] IN_valA,
   input  logic         IN_validA,
   input  logic         IN_lastA,
   output logic         OUT_readyA,
   input  logic [N-1:0] IN_valB,
   input  logic         IN_validB,
   input  logic         IN_lastB,
   output logic         OUT_readyB,
   input  logic [N-1:0] IN_valC,
   input  logic         IN_validC,
   input  logic         IN_lastC,
   output logic         OUT_readyC,
   input  logic         IN_ctrl,
   input  logic         IN_ready,
   output logic [N-1:0] OUT_valA,
   output logic         OUT_valid,
   output logic         OUT_last,
   output logic [2:0]   OUT_grant
);

   localparam int CW = $clog2(MAX_BURST + 1);

   state_t         state_q, state_d;
   logic [2:0]     grant_q, grant_d;
   req_idx_t       ptr_q, ptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   data_q;
   logic           valid_q;
   logic           last_q;

   logic [2:0]     valid_vec;
   logic [2:0]     rdy_vec;
   logic [2:0]     pick;
   logic [N-1:0]   sel_data;
   logic           sel_last;
   logic           space;
   logic           accept;
   logic [CW-1:0]  cnt_inc;
   logic           final_beat;

   assign valid_vec = {IN_validC, IN_validB, IN_validA};

   rr_pick3 u_pick (
      .req_i (valid_vec),
      .ptr_i (ptr_q),
      .gnt_o (pick)
   );

   always_comb begin
      sel_data = IN_valA;
      sel_last = IN_lastA;
      case (grant_q)
         GNT_B: begin
            sel_data = IN_valB;
            sel_last = IN_lastB;
         end
         GNT_C: begin
            sel_data = IN_valC;
            sel_last = IN_lastC;
         end
         default: ;
      endcase
   end

   assign space      = !valid_q || IN_ready;
   assign rdy_vec    = grant_q & {3{space}};
   assign accept     = |(rdy_vec & valid_vec);
   assign cnt_inc    = cnt_q + CW'(1);
   // The beat that fills MAX_BURST ends the burst even without a last flag.
   assign final_beat = accept && (sel_last || (cnt_inc == CW'(MAX_BURST)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= GNT_NONE;
         ptr_q   <= REQ_A;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (IN_ctrl && (|valid_vec)) begin
               grant_d = pick;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (final_beat) begin
               grant_d = GNT_NONE;
               ptr_d   = idx_next(onehot_to_idx(grant_q));
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (accept) begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      OUT_readyA = rdy_vec[0];
      OUT_readyB = rdy_vec[1];
      OUT_readyC = rdy_vec[2];
      OUT_valA   = data_q;
      OUT_valid  = valid_q;
      OUT_last   = last_q;
      OUT_grant  = grant_q;
   end

   // Output register holds everything while a beat waits on downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (accept) begin
         data_q  <= sel_data;
         valid_q <= 1'b1;
         last_q  <= final_beat;
      end else if (IN_ready) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_val_rr_arbiter.sv
// Directed bench for val_rr_arbiter: per-requester beat queues feed the DUT,
// expected output beats go into a scoreboard popped by an independent monitor.
module tb_val_rr_arbiter;

   typedef struct {
      logic [31:0] d;
      logic        l;
   } beat_t;

   logic        clk;
   logic        rst;
   logic [31:0] IN_valA, IN_valB, IN_valC;
   logic        IN_validA, IN_validB, IN_validC;
   logic        IN_lastA, IN_lastB, IN_lastC;
   logic        OUT_readyA, OUT_readyB, OUT_readyC;
   logic        IN_ctrl;
   logic        IN_ready;
   logic [31:0] OUT_valA;
   logic        OUT_valid;
   logic        OUT_last;
   logic [2:0]  OUT_grant;

   beat_t qa[$];
   beat_t qb[$];
   beat_t qc[$];
   beat_t exp_q[$];
   logic  gap_a;
   int    total = 0;
   int    bad   = 0;

   val_rr_arbiter #(.N(32), .MAX_BURST(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .IN_valA    (IN_valA),
      .IN_validA  (IN_validA),
      .IN_lastA   (IN_lastA),
      .OUT_readyA (OUT_readyA),
      .IN_valB    (IN_valB),
      .IN_validB  (IN_validB),
      .IN_lastB   (IN_lastB),
      .OUT_readyB (OUT_readyB),
      .IN_valC    (IN_valC),
      .IN_validC  (IN_validC),
      .IN_lastC   (IN_lastC),
      .OUT_readyC (OUT_readyC),
      .IN_ctrl    (IN_ctrl),
      .IN_ready   (IN_ready),
      .OUT_valA   (OUT_valA),
      .OUT_valid  (OUT_valid),
      .OUT_last   (OUT_last),
      .OUT_grant  (OUT_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_inputs();
      IN_validA = 1'b0; IN_valA = '0; IN_lastA = 1'b0;
      IN_validB = 1'b0; IN_valB = '0; IN_lastB = 1'b0;
      IN_validC = 1'b0; IN_valC = '0; IN_lastC = 1'b0;
      if (qa.size() > 0) begin
         IN_validA = !gap_a; IN_valA = qa[0].d; IN_lastA = qa[0].l;
      end
      if (qb.size() > 0) begin
         IN_validB = 1'b1; IN_valB = qb[0].d; IN_lastB = qb[0].l;
      end
      if (qc.size() > 0) begin
         IN_validC = 1'b1; IN_valC = qc[0].d; IN_lastC = qc[0].l;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic reset_pulse();
      tick();
      rst = 1'b1;
      gap_a = 1'b0;
      IN_ctrl = 1'b1;
      IN_ready = 1'b1;
      qa.delete(); qb.delete(); qc.delete();
      apply_inputs();
      tick();
      rst = 1'b0;
   endtask

   task automatic drain(input int n);
      repeat (n) tick();
      check("sb_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Requester driver: a beat leaves its queue once the DUT accepted it.
   initial begin
      logic acc_a, acc_b, acc_c;
      forever begin
         @(negedge clk);
         acc_a = IN_validA & OUT_readyA;
         acc_b = IN_validB & OUT_readyB;
         acc_c = IN_validC & OUT_readyC;
         @(posedge clk);
         #1;
         if (acc_a && qa.size() > 0) void'(qa.pop_front());
         if (acc_b && qb.size() > 0) void'(qb.pop_front());
         if (acc_c && qc.size() > 0) void'(qc.pop_front());
         apply_inputs();
      end
   end

   // Monitor: every downstream handshake must match the next expected beat.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (!rst && OUT_valid && IN_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_extra: got beat %0h expected none at %0t", OUT_valA, $time);
            end else begin
               e = exp_q.pop_front();
               check("sb_data", OUT_valA, e.d);
               check("sb_last", 32'(OUT_last), 32'(e.l));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got bad=%0d expected completion", bad);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      IN_ctrl = 1'b1;
      IN_ready = 1'b0;
      gap_a = 1'b0;
      apply_inputs();

      // Reset state and asynchronous reset with a beat in the output register
      tick(); tick();
      @(negedge clk);
      check("rst_valid", 32'(OUT_valid), 32'd0);
      check("rst_grant", 32'(OUT_grant), 32'd0);
      check("rst_last",  32'(OUT_last),  32'd0);
      check("rst_data",  OUT_valA,       32'd0);
      tick();
      rst = 1'b0;
      tick();
      qa.push_back('{32'h55, 1'b1});
      apply_inputs();
      @(negedge clk);
      @(negedge clk);
      check("pre_grant", 32'(OUT_grant), 32'b001);
      @(negedge clk);
      check("pre_valid", 32'(OUT_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_valid", 32'(OUT_valid), 32'd0);
      check("async_grant", 32'(OUT_grant), 32'd0);
      check("async_last",  32'(OUT_last),  32'd0);
      tick();
      rst = 1'b0;
      IN_ready = 1'b1;
      qa.delete();
      apply_inputs();
      tick();
      qa.push_back('{32'h11, 1'b1});
      exp_q.push_back('{32'h11, 1'b1});
      apply_inputs();
      @(negedge clk);
      check("lat_idle_grant", 32'(OUT_grant), 32'b000);
      @(negedge clk);
      check("lat_grant", 32'(OUT_grant), 32'b001);
      @(negedge clk);
      check("lat_data",  OUT_valA,        32'h11);
      check("lat_last",  32'(OUT_last),   32'd1);
      drain(4);

      // Fairness with one idle cycle between single-beat bursts
      reset_pulse();
      tick();
      qa.push_back('{32'hA0, 1'b1}); qa.push_back('{32'hA1, 1'b1});
      qb.push_back('{32'hB0, 1'b1}); qb.push_back('{32'hB1, 1'b1});
      qc.push_back('{32'hC0, 1'b1}); qc.push_back('{32'hC1, 1'b1});
      exp_q.push_back('{32'hA0, 1'b1}); exp_q.push_back('{32'hB0, 1'b1});
      exp_q.push_back('{32'hC0, 1'b1}); exp_q.push_back('{32'hA1, 1'b1});
      exp_q.push_back('{32'hB1, 1'b1}); exp_q.push_back('{32'hC1, 1'b1});
      apply_inputs();
      @(negedge clk);
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i >= 2) check("fair_valid", 32'(OUT_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      drain(4);

      // Backpressure on a 3-beat burst from B
      reset_pulse();
      tick();
      qb.push_back('{32'd1, 1'b0}); qb.push_back('{32'd2, 1'b0}); qb.push_back('{32'd3, 1'b1});
      exp_q.push_back('{32'd1, 1'b0}); exp_q.push_back('{32'd2, 1'b0}); exp_q.push_back('{32'd3, 1'b1});
      apply_inputs();
      tick(); tick();
      IN_ready = 1'b0;
      @(negedge clk);
      check("bp_data0",  OUT_valA,          32'd1);
      check("bp_rdyB0",  32'(OUT_readyB),   32'd0);
      tick();
      @(negedge clk);
      check("bp_data1",  OUT_valA,          32'd1);
      check("bp_valid1", 32'(OUT_valid),    32'd1);
      check("bp_rdyB1",  32'(OUT_readyB),   32'd0);
      tick();
      IN_ready = 1'b1;
      @(negedge clk);
      check("bp_rdyB2",  32'(OUT_readyB),   32'd1);
      drain(6);

      // Forced release after MAX_BURST beats from C, A served next, then C again
      reset_pulse();
      tick();
      for (int i = 1; i <= 6; i++) qc.push_back('{32'hC0 + 32'(i), 1'b0});
      for (int i = 1; i <= 4; i++) exp_q.push_back('{32'hC0 + 32'(i), (i == 4)});
      exp_q.push_back('{32'hA5, 1'b1});
      exp_q.push_back('{32'hC5, 1'b0});
      exp_q.push_back('{32'hC6, 1'b0});
      apply_inputs();
      tick();
      qa.push_back('{32'hA5, 1'b1});
      apply_inputs();
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 6) check("force_grantA", 32'(OUT_grant), 32'b001);
         if (i == 8) check("force_grantC", 32'(OUT_grant), 32'b100);
      end
      drain(6);

      // IN_ctrl gates new grants but never cuts a running burst
      reset_pulse();
      tick();
      IN_ctrl = 1'b0;
      qa.push_back('{32'h31, 1'b0}); qa.push_back('{32'h32, 1'b0}); qa.push_back('{32'h33, 1'b1});
      exp_q.push_back('{32'h31, 1'b0}); exp_q.push_back('{32'h32, 1'b0});
      exp_q.push_back('{32'h33, 1'b1}); exp_q.push_back('{32'h34, 1'b1});
      apply_inputs();
      for (int i = 0; i <= 3; i++) begin
         @(negedge clk);
         check("ctrl_off_grant", 32'(OUT_grant), 32'b000);
      end
      tick();
      IN_ctrl = 1'b1;
      tick();
      IN_ctrl = 1'b0;
      qa.push_back('{32'h34, 1'b1});
      apply_inputs();
      for (int i = 5; i <= 11; i++) begin
         @(negedge clk);
         check("ctrl_burst_grant", 32'(OUT_grant), (i <= 7) ? 32'b001 : 32'b000);
      end
      tick();
      IN_ctrl = 1'b1;
      drain(6);

      // Owner drops valid mid-burst; B waits for A's final beat
      reset_pulse();
      tick();
      qa.push_back('{32'h61, 1'b0}); qa.push_back('{32'h62, 1'b0}); qa.push_back('{32'h63, 1'b1});
      qb.push_back('{32'h6B, 1'b1});
      exp_q.push_back('{32'h61, 1'b0}); exp_q.push_back('{32'h62, 1'b0});
      exp_q.push_back('{32'h63, 1'b1}); exp_q.push_back('{32'h6B, 1'b1});
      apply_inputs();
      tick(); tick();
      gap_a = 1'b1;
      apply_inputs();
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         check("gap_grant", 32'(OUT_grant), 32'b001);
         check("gap_rdyB",  32'(OUT_readyB), 32'd0);
         tick();
      end
      gap_a = 1'b0;
      apply_inputs();
      @(negedge clk);
      check("gap_grant_p5", 32'(OUT_grant), 32'b001);
      @(negedge clk);
      check("gap_grant_p6", 32'(OUT_grant), 32'b001);
      @(negedge clk);
      @(negedge clk);
      check("gap_grantB", 32'(OUT_grant), 32'b010);
      drain(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
